// File: rtl/serializer_pkg.sv
// Shared types for the multi-lane serializer.
// State encoding and beat-count helper.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_PULSE,
    SEND_BITS,
    SEND_PARITY
  } ser_state_t;

  function automatic int beats_f(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding buffer.
// The shifter drains it through take.
module ser_hold_buf
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             take,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_buf
);

  assign in_ready = !hold_valid;

  // load and take never coincide: load needs an empty buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_buf   <= '0;
    end else if (in_valid && in_ready) begin
      hold_valid <= 1'b1;
      hold_buf   <= data_in;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer_mlane.sv
// Multi-lane word serializer with start pulse,
// optional parity beat and back-to-back streaming.
module serializer_mlane
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [LANES-1:0] serial_out,
  output logic             start,
  output logic             frame_done,
  output logic             busy
);

  localparam int BEATS = beats_f(WIDTH, LANES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serializer_mlane: WIDTH must be >= 2");
  end
  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("serializer_mlane: WIDTH must be a multiple of LANES");
  end

  ser_state_t       state;
  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_buf;
  logic             take;
  logic             last;
  logic             eof;
  logic [LANES-1:0] beat0;
  logic [LANES-1:0] beat_nxt;
  logic [LANES-1:0] par_beat;

  function automatic logic [LANES-1:0] slice_f(
    input logic [WIDTH-1:0] w,
    input logic [CW-1:0]    k
  );
    int base;
    if (int'(k) >= BEATS) return '0;
    if (MSB_FIRST) base = WIDTH - LANES * (int'(k) + 1);
    else           base = int'(k) * LANES;
    return w[base +: LANES];
  endfunction

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (take),
    .hold_valid(hold_valid),
    .hold_buf  (hold_buf)
  );

  always_comb begin
    cnt_nxt     = cnt + CW'(1);
    last        = (cnt == LAST);
    eof         = (state == SEND_PARITY) ||
                  (state == SEND_BITS && last && !PARITY_EN);
    take        = hold_valid && (state == IDLE || eof);
    beat0       = slice_f(shadow, '0);
    beat_nxt    = slice_f(shadow, cnt_nxt);
    par_beat    = '0;
    par_beat[0] = ^shadow;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      serial_out <= '0;
      start      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          serial_out <= '0;
          start      <= 1'b0;
          if (hold_valid) begin
            shadow <= hold_buf;
            start  <= 1'b1;
            state  <= START_PULSE;
          end
        end
        START_PULSE: begin
          start      <= 1'b0;
          cnt        <= '0;
          serial_out <= beat0;
          frame_done <= (BEATS == 1) && !PARITY_EN;
          state      <= SEND_BITS;
        end
        SEND_BITS, SEND_PARITY: begin
          if (eof) begin
            // chain straight into the next frame when a word waits
            serial_out <= '0;
            if (hold_valid) begin
              shadow <= hold_buf;
              start  <= 1'b1;
              state  <= START_PULSE;
            end else begin
              state <= IDLE;
            end
          end else if (!last) begin
            cnt        <= cnt_nxt;
            serial_out <= beat_nxt;
            frame_done <= (cnt_nxt == LAST) && !PARITY_EN;
          end else begin
            serial_out <= par_beat;
            frame_done <= 1'b1;
            state      <= SEND_PARITY;
          end
        end
        default: begin
          serial_out <= '0;
          start      <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_mlane.sv
// Scoreboard bench for serializer_mlane in three
// configurations: LSB x1, MSB x2, LSB x1 with parity.
module tb_serializer_mlane;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [7:0] d_a = '0, d_b = '0, d_c = '0;
  logic       v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic       r_a, r_b, r_c;
  logic [0:0] so_a, so_c;
  logic [1:0] so_b;
  logic       st_a, st_b, st_c;
  logic       fd_a, fd_b, fd_c;
  logic       bz_a, bz_b, bz_c;

  serializer_mlane #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .rst(rst), .data_in(d_a), .in_valid(v_a), .in_ready(r_a),
    .serial_out(so_a), .start(st_a), .frame_done(fd_a), .busy(bz_a)
  );

  serializer_mlane #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .data_in(d_b), .in_valid(v_b), .in_ready(r_b),
    .serial_out(so_b), .start(st_b), .frame_done(fd_b), .busy(bz_b)
  );

  serializer_mlane #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_c (
    .clk(clk), .rst(rst), .data_in(d_c), .in_valid(v_c), .in_ready(r_c),
    .serial_out(so_c), .start(st_c), .frame_done(fd_c), .busy(bz_c)
  );

  typedef struct {
    logic [8:0] w;
    logic       fd_last;
    logic       fd_extra;
    int         scyc;
  } obs_t;

  logic [8:0] sb_a[$], sb_b[$], sb_c[$];
  obs_t       ob_a[$], ob_b[$], ob_c[$];
  int         starts_a = 0;
  int         xfer_cyc = 0;

  // monitors: rebuild each frame from the pins, no judging here
  int ka = -1, kb = -1, kc = -1;
  logic [7:0] wa, wb, wc;
  logic fxa, fxb, fxc;
  int sca, scb, scc;

  always @(negedge clk) begin
    obs_t o;
    if (rst) ka = -1;
    else if (st_a) begin ka = 0; fxa = 0; sca = cyc; starts_a++; end
    else if (ka >= 0) begin
      wa[3'(ka)] = so_a[0];
      if (ka == 7) begin
        o.w = {1'b0, wa}; o.fd_last = fd_a; o.fd_extra = fxa; o.scyc = sca;
        ob_a.push_back(o); ka = -1;
      end else begin
        if (fd_a) fxa = 1; ka++;
      end
    end
  end

  always @(negedge clk) begin
    obs_t o;
    if (rst) kb = -1;
    else if (st_b) begin kb = 0; fxb = 0; scb = cyc; end
    else if (kb >= 0) begin
      wb = {wb[5:0], so_b};
      if (kb == 3) begin
        o.w = {1'b0, wb}; o.fd_last = fd_b; o.fd_extra = fxb; o.scyc = scb;
        ob_b.push_back(o); kb = -1;
      end else begin
        if (fd_b) fxb = 1; kb++;
      end
    end
  end

  always @(negedge clk) begin
    obs_t o;
    if (rst) kc = -1;
    else if (st_c) begin kc = 0; fxc = 0; scc = cyc; end
    else if (kc >= 0) begin
      if (kc == 8) begin
        o.w = {so_c[0], wc}; o.fd_last = fd_c; o.fd_extra = fxc; o.scyc = scc;
        ob_c.push_back(o); kc = -1;
      end else begin
        wc[3'(kc)] = so_c[0];
        if (fd_c) fxc = 1; kc++;
      end
    end
  end

  // beat k of a 2-lane MSB-first word is word[6-2k +: 2]; pack beats in send order
  function automatic logic [8:0] model_b(input logic [7:0] w);
    logic [7:0] r = '0;
    for (int k = 0; k < 4; k++) r = {r[5:0], w[6-2*k +: 2]};
    return {1'b0, r};
  endfunction

  task automatic send_a(input logic [7:0] w);
    int n = 0;
    @(negedge clk); #1;
    while (r_a !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (r_a !== 1'b1) begin
      errors++; $display("FAIL send_a_ready got %b want 1", r_a);
    end else begin
      d_a = w; v_a = 1'b1; sb_a.push_back({1'b0, w}); xfer_cyc = cyc + 1;
      @(posedge clk); #1; v_a = 1'b0;
    end
  endtask

  task automatic send_b(input logic [7:0] w);
    int n = 0;
    @(negedge clk); #1;
    while (r_b !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (r_b !== 1'b1) begin
      errors++; $display("FAIL send_b_ready got %b want 1", r_b);
    end else begin
      d_b = w; v_b = 1'b1; sb_b.push_back(model_b(w));
      @(posedge clk); #1; v_b = 1'b0;
    end
  endtask

  task automatic send_c(input logic [7:0] w);
    int n = 0;
    @(negedge clk); #1;
    while (r_c !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (r_c !== 1'b1) begin
      errors++; $display("FAIL send_c_ready got %b want 1", r_c);
    end else begin
      d_c = w; v_c = 1'b1; sb_c.push_back({^w, w});
      @(posedge clk); #1; v_c = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; v_a = 1'b1; d_a = 8'hEE;
    repeat (3) @(negedge clk);
    #1;
    checks += 7;
    if (so_a !== 1'b0) begin errors++; $display("FAIL rst_serial got %b want 0", so_a); end
    if (st_a !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", st_a); end
    if (fd_a !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", fd_a); end
    if (bz_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bz_a); end
    if (r_a !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", r_a); end
    if (so_b !== 2'b00) begin errors++; $display("FAIL rst_serial_b got %b want 00", so_b); end
    if (bz_c !== 1'b0) begin errors++; $display("FAIL rst_busy_c got %b want 0", bz_c); end
    v_a = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks += 2;
    if (starts_a !== 0) begin errors++; $display("FAIL rst_nocapture starts got %0d want 0", starts_a); end
    if (bz_a !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", bz_a); end
  endtask

  task automatic test_lsb_frame();
    obs_t o;
    logic [8:0] e;
    send_a(8'hA5);
    for (int c = 0; c < 40 && ob_a.size() < 1; c++) begin @(negedge clk); #1; end
    checks++;
    if (ob_a.size() < 1) begin errors++; $display("FAIL lsb_timeout frames got 0 want 1"); return; end
    o = ob_a.pop_front(); e = sb_a.pop_front();
    checks += 4;
    if (o.w !== e) begin errors++; $display("FAIL lsb_word got %h want %h", o.w, e); end
    if (o.fd_last !== 1'b1) begin errors++; $display("FAIL lsb_done_last got %b want 1", o.fd_last); end
    if (o.fd_extra !== 1'b0) begin errors++; $display("FAIL lsb_done_early got %b want 0", o.fd_extra); end
    if (o.scyc - xfer_cyc !== 1) begin
      errors++; $display("FAIL lsb_latency got %0d want 1", o.scyc - xfer_cyc);
    end
    @(negedge clk); #1;
    checks += 3;
    if (so_a !== 1'b0) begin errors++; $display("FAIL lsb_idle_out got %b want 0", so_a); end
    if (bz_a !== 1'b0) begin errors++; $display("FAIL lsb_idle_busy got %b want 0", bz_a); end
    if (fd_a !== 1'b0) begin errors++; $display("FAIL lsb_done_clear got %b want 0", fd_a); end
  endtask

  task automatic test_msb_lanes();
    obs_t o;
    logic [8:0] e;
    send_b(8'hB4);
    send_b(8'h1E);
    for (int c = 0; c < 40 && ob_b.size() < 2; c++) begin @(negedge clk); #1; end
    checks++;
    if (ob_b.size() < 2) begin errors++; $display("FAIL msb_timeout frames got %0d want 2", ob_b.size()); return; end
    for (int i = 0; i < 2; i++) begin
      o = ob_b.pop_front(); e = sb_b.pop_front();
      checks += 3;
      if (o.w !== e) begin errors++; $display("FAIL msb_beats got %h want %h", o.w, e); end
      if (o.fd_last !== 1'b1) begin errors++; $display("FAIL msb_done got %b want 1", o.fd_last); end
      if (o.fd_extra !== 1'b0) begin errors++; $display("FAIL msb_done_early got %b want 0", o.fd_extra); end
    end
  endtask

  task automatic test_parity();
    obs_t o, p;
    logic [8:0] e;
    send_c(8'h07);
    send_c(8'h03);
    for (int c = 0; c < 60 && ob_c.size() < 2; c++) begin @(negedge clk); #1; end
    checks++;
    if (ob_c.size() < 2) begin errors++; $display("FAIL par_timeout frames got %0d want 2", ob_c.size()); return; end
    for (int i = 0; i < 2; i++) begin
      o = ob_c.pop_front(); e = sb_c.pop_front();
      checks += 3;
      if (o.w !== e) begin errors++; $display("FAIL par_frame got %h want %h", o.w, e); end
      if (o.fd_last !== 1'b1) begin errors++; $display("FAIL par_done got %b want 1", o.fd_last); end
      if (o.fd_extra !== 1'b0) begin errors++; $display("FAIL par_done_early got %b want 0", o.fd_extra); end
      if (i == 1) begin
        checks++;
        if (o.scyc - p.scyc !== 10) begin
          errors++; $display("FAIL par_period got %0d want 10", o.scyc - p.scyc);
        end
      end
      p = o;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ws[3];
    obs_t o, p;
    logic [8:0] e;
    int i = 0, rises = 0, idle = 0, base;
    logic prev;
    ws[0] = 8'h11; ws[1] = 8'h22; ws[2] = 8'h33;
    base = starts_a;
    @(negedge clk); #1;
    prev = r_a;
    for (int c = 0; c < 200 && ob_a.size() < 3; c++) begin
      if (r_a === 1'b1 && prev !== 1'b1) rises++;
      prev = r_a;
      if (starts_a > base && bz_a !== 1'b1) idle++;
      if (i < 3) begin
        d_a = ws[i]; v_a = 1'b1;
        if (r_a === 1'b1) begin sb_a.push_back({1'b0, ws[i]}); i++; end
      end else begin
        v_a = 1'b0;
      end
      @(negedge clk); #1;
    end
    v_a = 1'b0;
    checks++;
    if (ob_a.size() < 3) begin errors++; $display("FAIL b2b_timeout frames got %0d want 3", ob_a.size()); return; end
    for (int k = 0; k < 3; k++) begin
      o = ob_a.pop_front(); e = sb_a.pop_front();
      checks++;
      if (o.w !== e) begin errors++; $display("FAIL b2b_word got %h want %h", o.w, e); end
      if (k > 0) begin
        checks++;
        if (o.scyc - p.scyc !== 9) begin
          errors++; $display("FAIL b2b_period got %0d want 9", o.scyc - p.scyc);
        end
      end
      p = o;
    end
    checks += 2;
    if (idle !== 0) begin errors++; $display("FAIL b2b_idle got %0d want 0", idle); end
    if (rises !== 3) begin errors++; $display("FAIL b2b_ready_rises got %0d want 3", rises); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    obs_t o;
    logic [8:0] e;
    send_a(8'h3C);
    send_a(8'hC3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (r_a !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", r_a); end
      d_a = 8'hFF; v_a = 1'b1;
    end
    @(negedge clk); #1;
    v_a = 1'b0;
    send_a(8'h5A);
    for (int c = 0; c < 80 && ob_a.size() < 3; c++) begin @(negedge clk); #1; end
    checks++;
    if (ob_a.size() < 3) begin errors++; $display("FAIL bp_timeout frames got %0d want 3", ob_a.size()); return; end
    for (int k = 0; k < 3; k++) begin
      o = ob_a.pop_front(); e = sb_a.pop_front();
      checks++;
      if (o.w !== e) begin errors++; $display("FAIL bp_word got %h want %h", o.w, e); end
    end
    repeat (15) @(negedge clk);
    #1;
    checks++;
    if (ob_a.size() !== 0) begin errors++; $display("FAIL bp_extra_frame got %0d want 0", ob_a.size()); end
  endtask

  task automatic test_reset_midframe();
    obs_t o;
    logic [8:0] e;
    int base;
    send_a(8'hFF);
    send_a(8'h69);
    for (int c = 0; c < 40 && ka != 4; c++) begin @(negedge clk); #1; end
    checks++;
    if (ka != 4) begin errors++; $display("FAIL mid_reach_beat3 got %0d want 4", ka); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (so_a !== 1'b0) begin errors++; $display("FAIL mid_serial got %b want 0", so_a); end
    if (st_a !== 1'b0) begin errors++; $display("FAIL mid_start got %b want 0", st_a); end
    if (fd_a !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", fd_a); end
    if (bz_a !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", bz_a); end
    if (r_a !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", r_a); end
    sb_a.delete();
    ob_a.delete();
    @(negedge clk); #1;
    rst = 1'b0;
    base = starts_a;
    repeat (15) @(negedge clk);
    #1;
    checks += 2;
    if (starts_a !== base) begin errors++; $display("FAIL mid_no_start got %0d want %0d", starts_a, base); end
    if (ob_a.size() !== 0) begin errors++; $display("FAIL mid_no_frame got %0d want 0", ob_a.size()); end
    send_a(8'h0F);
    for (int c = 0; c < 40 && ob_a.size() < 1; c++) begin @(negedge clk); #1; end
    checks++;
    if (ob_a.size() < 1) begin errors++; $display("FAIL mid_timeout frames got 0 want 1"); return; end
    o = ob_a.pop_front(); e = sb_a.pop_front();
    checks++;
    if (o.w !== e) begin errors++; $display("FAIL mid_after_word got %h want %h", o.w, e); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_frame();
    test_msb_lanes();
    test_parity();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
